// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the multiplier and divider datapath blocks.
// Format is UQ(FXP_WIDTH-FXP_FRAC).FXP_FRAC; ONE is the encoding of 1.0.
package fxp_pkg;

  localparam int FXP_WIDTH = 10;
  localparam int FXP_FRAC  = 4;
  localparam int ONE       = 1 << FXP_FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the shift-add multiplier: counts 0..TERM-1 while enabled,
// wraps to 0, and raises co during the last counted cycle.
module mul_iter_cnt #(
  parameter int TERM = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic co
);

  localparam int CW = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(TERM - 1));
  assign co   = en & last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential shift-add unsigned fixed-point multiplier: P = (A*B) >> FRAC, one
// multiplier bit per cycle. Define FXP_MUL_ROUND_EN for round-half-up instead of truncation.
//
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE; done is a
// one-cycle pulse registered out of DONE, with P/ov/zero valid from that cycle and
// held until the next done. ld_a/ld_b are ignored while busy.
module fixed_point_multiplier
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_WIDTH,
  parameter int FRAC  = FXP_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P,
  output logic             ov,
  output logic             zero,
  output logic             cnt_co
);

  localparam int PW = 2 * WIDTH;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc, mcand;
  logic             start_ok;
  logic             run_en;
  logic [PW:0]      full_adj;
  logic [WIDTH-1:0] p_nxt;
  logic             ov_nxt;

  assign start_ok = (state == IDLE) && start;
  assign run_en   = (state == RUN);
  assign busy     = (state != IDLE);

  mul_iter_cnt #(
    .TERM (WIDTH)
  ) u_iter_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  (run_en),
    .co  (cnt_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_co) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (state == IDLE) begin
      if (ld_a) a_reg <= A;
      if (ld_b) b_reg <= B;
    end
  end

  // Operands loaded in the start cycle bypass the registers so they take effect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start_ok) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, (ld_a ? A : a_reg)};
      mplier <= ld_b ? B : b_reg;
    end else if (run_en) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

`ifdef FXP_MUL_ROUND_EN
  assign full_adj = {1'b0, acc} + ((PW + 1)'(1) << (FRAC - 1));
`else
  assign full_adj = {1'b0, acc};
`endif

  assign p_nxt  = WIDTH'(full_adj >> FRAC);
  assign ov_nxt = |(full_adj >> (WIDTH + FRAC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      P    <= '0;
      ov   <= 1'b0;
      zero <= 1'b1;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        P    <= p_nxt;
        ov   <= ov_nxt;
        zero <= (p_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed bench for fixed_point_multiplier; expectations follow FXP_MUL_ROUND_EN when defined.
module tb_fixed_point_multiplier;
  import fxp_pkg::*;

  localparam int W = FXP_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_a, ld_b, start;
  logic [W-1:0] A, B;
  logic         busy, done, ov, zero, cnt_co;
  logic [W-1:0] P;

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  fixed_point_multiplier dut (
    .clk    (clk),
    .rst    (rst),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .A      (A),
    .B      (B),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .P      (P),
    .ov     (ov),
    .zero   (zero),
    .cnt_co (cnt_co)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one multiplication and checks latency, carry-out timing, result and pulse width.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic do_ld, input logic mid_ld,
                         input logic [W-1:0] exp_p, input logic exp_ov, input logic exp_z);
    int cycles;
    int co_hits;
    int co_at;
    logic seen;
    logic [W-1:0] want;
    @(negedge clk);
    A = a; B = b; ld_a = do_ld; ld_b = do_ld; start = 1'b1;
    exp_q.push_back(exp_p);
    @(posedge clk); #1;
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cycles = 0; co_hits = 0; co_at = -1; seen = 1'b0;
    while (!seen && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (cnt_co) begin co_hits++; co_at = cycles; end
      if (mid_ld && cycles == 3) begin A = 10'd1023; ld_a = 1'b1; end
      if (mid_ld && cycles == 4) ld_a = 1'b0;
      if (done) seen = 1'b1;
    end
    want = exp_q.pop_front();
    check({tag, "_latency"}, cycles, 11);
    check({tag, "_co_hits"}, co_hits, 1);
    check({tag, "_co_cycle"}, co_at, 9);
    check({tag, "_P"}, P, want);
    check({tag, "_ov"}, ov, exp_ov);
    check({tag, "_zero"}, zero, exp_z);
    check({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, done, 0);
    check({tag, "_P_held"}, P, want);
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    int done_hits;

    rst = 1'b1; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_P", P, 0);
    check("rst_ov", ov, 0);
    check("rst_zero", zero, 1);
    check("rst_cnt_co", cnt_co, 0);
    @(negedge clk);
    rst = 1'b0;

    run_mul("mul_1p5x2", 10'd24, 10'd32, 1'b1, 1'b0, 10'd48, 1'b0, 1'b0);
    run_mul("max_sq", 10'd1023, 10'd1023, 1'b1, 1'b0, 10'd896, 1'b1, 1'b0);
    run_mul("a_zero", 10'd0, 10'd500, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1);
`ifdef FXP_MUL_ROUND_EN
    run_mul("a1_b8", 10'd1, 10'd8, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0);
    run_mul("round_carry", 10'd129, 10'd127, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1);
`else
    run_mul("a1_b8", 10'd1, 10'd8, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1);
    run_mul("round_carry", 10'd129, 10'd127, 1'b1, 1'b0, 10'd1023, 1'b0, 1'b0);
`endif
    run_mul("one_x_max", W'(ONE), 10'd1023, 1'b1, 1'b0, 10'd1023, 1'b0, 1'b0);
    run_mul("ovf_edge", 10'd32, 10'd512, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1);
    run_mul("ld_mid_run", 10'd24, 10'd32, 1'b1, 1'b1, 10'd48, 1'b0, 1'b0);
    run_mul("no_reload", 10'd0, 10'd0, 1'b0, 1'b0, 10'd48, 1'b0, 1'b0);

    // start held for 20 edges: accepted at edge 0 and again in the IDLE cycle after DONE
    @(negedge clk);
    A = 10'd24; B = 10'd32; ld_a = 1'b1; ld_b = 1'b1; start = 1'b1;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin ld_a = 1'b0; ld_b = 1'b0; end
      if (i == 19) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
      end
    end
    check("held_pulses", pulses, 2);
    check("held_first", first_at, 11);
    check("held_second", second_at, 23);
    check("held_P", P, 48);

    // reset asserted in RUN cycle 5 aborts the operation
    @(negedge clk);
    A = 10'd1023; B = 10'd1023; ld_a = 1'b1; ld_b = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_P", P, 0);
    check("mid_rst_zero", zero, 1);
    check("mid_rst_ov", ov, 0);
    @(negedge clk);
    rst = 1'b0;
    done_hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) done_hits++;
    end
    check("aborted_no_done", done_hits, 0);
    run_mul("post_rst", 10'd16, 10'd16, 1'b1, 1'b0, 10'd16, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fixed_point_multiplier.md
Name: fixed_point_multiplier

Overview:
- Sequential shift-add multiplier for unsigned fixed-point operands; the inverse operation of the team's fixed_point_division block.
- Uses the same operand format, the same load/start handshake style, and the same counter-driven iteration.
- Sits beside the divider in the arithmetic datapath, so a controller can scale a value back after dividing.
- Computes P = (A*B) >> FRAC over WIDTH iterations, one multiplier bit per cycle, and flags overflow and zero.

Parameters:
- WIDTH, 10: operand and result width in bits.
- FRAC, 4: number of fractional bits; the format is UQ(WIDTH-FRAC).FRAC, so 1.0 = 16 at default.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ld_a  input  1  load A into the multiplicand register; ignored while busy.
- ld_b  input  1  load B into the multiplier register; ignored while busy.
- A  input  WIDTH  multiplicand operand.
- B  input  WIDTH  multiplier operand.
- start  input  1  begin multiplication; sampled only in IDLE.
- busy  output  1  high during RUN and DONE.
- done  output  1  one-cycle pulse when P is valid.
- P  output  WIDTH  fixed-point product; held until the next done.
- ov  output  1  result does not fit in WIDTH bits; valid with P and held with P.
- zero  output  1  P == 0; held with P.
- cnt_co  output  1  iteration counter carry-out, high in the last RUN cycle.

Behaviour:
Reset (async, immediate):
- State = IDLE; counter = 0; accumulator = 0; P = 0; ov = 0; zero = 1; done = 0; busy = 0.
- Operand registers are cleared to 0.
- Reset asserted mid-RUN aborts the operation; no done pulse is produced.

Operand registers:
- ld_a / ld_b capture A / B on the clock edge when not busy.
- ld_a/ld_b together with start in the same cycle: the operands load and start is also accepted; the multiplication uses the newly loaded values.

States:
- IDLE: start=1 -> RUN. On entry to RUN: acc (2*WIDTH bits) = 0, mcand (2*WIDTH bits) = zero-extended A, mplier = B, counter = 0.
- RUN: each cycle:
  - if mplier[0], then acc += mcand;
  - mcand <<= 1; mplier >>= 1; counter++.
  - After WIDTH cycles (cnt_co=1 in cycle WIDTH) -> DONE.
- DONE: register P, ov and zero; done=1 for exactly this cycle; -> IDLE.

Latency and handshake:
- start sampled at edge N -> done high in the cycle after edge N+WIDTH+1.
- At defaults this is 11 clocks from the start edge to the done cycle.
- start while busy is ignored; it is not queued.
- Back-to-back: start may be asserted in the cycle following DONE (IDLE).

Arithmetic:
- full = acc (exact 2*WIDTH-bit product).
- P = full[WIDTH+FRAC-1 : FRAC]; the fraction is truncated.
- ov = |full[2*WIDTH-1 : WIDTH+FRAC]. When ov=1, P holds the wrapped low bits; there is no saturation.
- zero reflects the final P.
- A=0 or B=0: still takes the full WIDTH cycles; P=0, zero=1, ov=0.

Optional Feature:
- FXP_MUL_ROUND_EN defined:
  - P = (full + 2^(FRAC-1))[WIDTH+FRAC-1 : FRAC], i.e. round-half-up.
  - ov is also computed on the rounded sum, so a carry out of rounding counts as overflow.
  - Latency is unchanged; the add happens in the DONE cycle.
- Undefined: plain truncation as above.

Decomposition:
- Shared package fxp_pkg holds:
  - WIDTH and FRAC defaults, shared with fixed_point_division;
  - the state enum typedef (IDLE, RUN, DONE);
  - the constant ONE = 1 << FRAC.
- One sub-module: mul_iter_cnt, a WIDTH-terminal iteration counter with clear, enable and carry-out.
  - Parameterised sibling of the divider's mod-14 counter.
  - Drives cnt_co.

Test Plan:
- A=24 (1.5), B=32 (2.0), start -> done exactly 11 cycles later; P=48 (3.0), ov=0, zero=0.
- A=1023, B=1023 -> full=1046529; P=896, ov=1.
- A=0, B=500 -> done after 11 cycles; P=0, zero=1, ov=0.
- A=1, B=8:
  - truncation build -> P=0, zero=1;
  - FXP_MUL_ROUND_EN build -> P=1, zero=0.
- Handshake and reset:
  - start=1 held for 20 cycles -> exactly one done pulse per accepted start, at cycles 11 and 23 (start re-accepted in the IDLE cycle);
  - ld_a pulsed mid-RUN -> P unaffected.
- Reset mid-RUN: rst=1 in RUN cycle 5 -> no done pulse; immediately busy=0, P=0, zero=1. Then a new start with A=16, B=16 -> P=16.
